// File: rtl/int_dispatch.sv
// Interrupt dispatch front end: polls the controller's pending register, requests the
// core, and clears the serviced bit by read-modify-write. Optional macro: INT_DISPATCH_ROUNDROBIN_EN.
module int_dispatch #(
   parameter int          NUM_VECTORS  = 8,
   parameter int          ID_W         = 3,
   parameter logic [15:0] RD_ADDRESS   = 16'h00EF,
   parameter logic [15:0] WR_ADDRESS   = 16'h00FF,
   parameter logic [15:0] IDLE_ADDRESS = 16'h0000,
   parameter int          POLL_DIV     = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   output logic [15:0]            address_o,
   output logic                   we_o,
   output logic [NUM_VECTORS-1:0] wdata_o,
   input  logic [NUM_VECTORS-1:0] rdata_i,
   input  logic [NUM_VECTORS-1:0] mask_i,
   output logic                   irq_o,
   input  logic                   ack_i,
   output logic [ID_W-1:0]        vector_id_o,
   output logic                   vector_valid_o,
   input  logic                   eoi_i
);

   localparam int CNT_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_DIV - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      POLL   = 3'd1,
      REQ    = 3'd2,
      ACTIVE = 3'd3,
      CLR_RD = 3'd4,
      CLR_WR = 3'd5
   } state_t;

   state_t                 state;
   state_t                 next_state;
   logic [CNT_W-1:0]       poll_cnt;
   logic [NUM_VECTORS-1:0] cand;
   logic [NUM_VECTORS-1:0] clr_mask;
   logic [ID_W-1:0]        pick;
   logic [ID_W-1:0]        sel_id;
   logic [15:0]            addr_next;
   logic                   ack_q;
   logic                   ack_rise;

`ifdef INT_DISPATCH_ROUNDROBIN_EN
   logic [ID_W-1:0]        rr_ptr;

   // First set bit at or after ptr, wrapping past the top vector back to bit 0.
   function automatic logic [ID_W-1:0] select_vec(input logic [NUM_VECTORS-1:0] v,
                                                  input logic [ID_W-1:0]        ptr);
      logic                   found;
      logic [NUM_VECTORS-1:0] sh;
      int                     idx;
      select_vec = '0;
      found      = 1'b0;
      for (int i = 0; i < NUM_VECTORS; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_VECTORS) idx = idx - NUM_VECTORS;
         sh = v >> idx;
         if (!found && sh[0]) begin
            found      = 1'b1;
            select_vec = ID_W'(idx);
         end
      end
   endfunction

   always_ff @(posedge clk) begin
      if (!reset_n)
         rr_ptr <= '0;
      else if (state == CLR_WR)
         rr_ptr <= (sel_id == ID_W'(NUM_VECTORS - 1)) ? '0 : sel_id + ID_W'(1);
   end

   assign pick = select_vec(cand, rr_ptr);
`else
   // Fixed priority: bit 0 wins.
   function automatic logic [ID_W-1:0] select_vec(input logic [NUM_VECTORS-1:0] v);
      logic [NUM_VECTORS-1:0] sh;
      select_vec = '0;
      for (int i = NUM_VECTORS - 1; i >= 0; i--) begin
         sh = v >> i;
         if (sh[0]) select_vec = ID_W'(i);
      end
   endfunction

   assign pick = select_vec(cand);
`endif

   assign cand     = rdata_i & ~mask_i;
   assign clr_mask = ~(NUM_VECTORS'(1) << sel_id);
   // A held acknowledge must act only once.
   assign ack_rise = ack_i & ~ack_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         poll_cnt <= '0;
         ack_q    <= 1'b0;
      end else begin
         state <= next_state;
         ack_q <= ack_i;
         if (state == IDLE && poll_cnt != CNT_LAST)
            poll_cnt <= poll_cnt + CNT_W'(1);
         else
            poll_cnt <= '0;
      end
   end

   always_comb begin
      next_state = state;
      addr_next  = IDLE_ADDRESS;
      case (state)
         IDLE:    if (poll_cnt == CNT_LAST) next_state = POLL;
         POLL:    next_state = (cand != '0) ? REQ : IDLE;
         REQ:     if (ack_rise) next_state = ACTIVE;
         ACTIVE:  if (eoi_i) next_state = CLR_RD;
         CLR_RD:  next_state = CLR_WR;
         CLR_WR:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
      case (next_state)
         POLL, CLR_RD: addr_next = RD_ADDRESS;
         CLR_WR:       addr_next = WR_ADDRESS;
         default:      addr_next = IDLE_ADDRESS;
      endcase
   end

   always_ff @(posedge clk) begin
      if (state == POLL && cand != '0)
         sel_id <= pick;
   end

   // Outputs are registered from the next state so they change on the entering edge.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         address_o      <= IDLE_ADDRESS;
         we_o           <= 1'b0;
         wdata_o        <= '0;
         irq_o          <= 1'b0;
         vector_id_o    <= '0;
         vector_valid_o <= 1'b0;
      end else begin
         address_o      <= addr_next;
         we_o           <= (next_state == CLR_WR);
         wdata_o        <= (next_state == CLR_WR) ? (rdata_i & clr_mask) : '0;
         irq_o          <= (next_state == REQ);
         vector_valid_o <= (next_state == ACTIVE) || (next_state == CLR_RD);
         if (state == REQ && next_state == ACTIVE)
            vector_id_o <= sel_id;
      end
   end

endmodule

// File: tb/tb_int_dispatch.sv
// Directed bench for int_dispatch with a small pending-register model of the controller.
module tb_int_dispatch;

   localparam logic [15:0] RD = 16'h00EF;
   localparam logic [15:0] WR = 16'h00FF;
   localparam int          PD = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] address_o;
   logic        we_o;
   logic [7:0]  wdata_o;
   logic [7:0]  rdata_i;
   logic [7:0]  mask_i;
   logic        irq_o;
   logic        ack_i;
   logic [2:0]  vector_id_o;
   logic        vector_valid_o;
   logic        eoi_i;

   logic [7:0]  ctrl_reg = 8'h00;
   logic        load_en;
   logic [7:0]  load_val;
   logic [7:0]  arrive;
   int          wr_cnt = 0;
   int          bad_wr = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   int_dispatch dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .address_o      (address_o),
      .we_o           (we_o),
      .wdata_o        (wdata_o),
      .rdata_i        (rdata_i),
      .mask_i         (mask_i),
      .irq_o          (irq_o),
      .ack_i          (ack_i),
      .vector_id_o    (vector_id_o),
      .vector_valid_o (vector_valid_o),
      .eoi_i          (eoi_i)
   );

   // Controller model: data only valid at the read address, garbage elsewhere.
   assign rdata_i = (address_o == RD) ? ctrl_reg : 8'hA5;

   always @(posedge clk) begin
      if (load_en)
         ctrl_reg <= load_val;
      else if (we_o && address_o == WR) begin
         ctrl_reg <= wdata_o | arrive;
         wr_cnt   <= wr_cnt + 1;
      end else
         ctrl_reg <= ctrl_reg | arrive;
      if (we_o && address_o != WR) bad_wr <= bad_wr + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [7:0] v);
      load_val = v;
      load_en  = 1'b1;
      @(negedge clk);
      load_en  = 1'b0;
   endtask

   task automatic grant(input logic [2:0] exp_id);
      int n = 0;
      while (irq_o !== 1'b1 && n < PD + 2) begin
         @(negedge clk);
         n++;
      end
      check("irq_rise", irq_o, 1);
      check("valid_before_ack", vector_valid_o, 0);
      ack_i = 1'b1;
      @(negedge clk);
      ack_i = 1'b0;
      check("valid_after_ack", vector_valid_o, 1);
      check("vector_id", vector_id_o, exp_id);
      check("irq_after_ack", irq_o, 0);
   endtask

   task automatic finish(input logic [7:0] exp_wdata);
      int w0 = wr_cnt;
      eoi_i = 1'b1;
      @(negedge clk);
      eoi_i = 1'b0;
      check("clr_rd_addr", address_o, RD);
      check("clr_rd_we", we_o, 0);
      @(negedge clk);
      check("clr_wr_addr", address_o, WR);
      check("clr_wr_we", we_o, 1);
      check("clr_wr_data", wdata_o, exp_wdata);
      check("clr_wr_valid", vector_valid_o, 0);
      @(negedge clk);
      check("post_wr_we", we_o, 0);
      check("post_wr_addr", address_o, 16'h0000);
      check("write_count", wr_cnt - w0, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_addr"}, address_o, 16'h0000);
      check({tag, "_we"}, we_o, 0);
      check({tag, "_wdata"}, wdata_o, 8'h00);
      check({tag, "_irq"}, irq_o, 0);
      check({tag, "_id"}, vector_id_o, 3'd0);
      check({tag, "_valid"}, vector_valid_o, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int quiet_bad;
      int w0;
      reset_n  = 1'b0;
      ack_i    = 1'b0;
      eoi_i    = 1'b0;
      mask_i   = 8'h00;
      load_en  = 1'b0;
      load_val = 8'h00;
      arrive   = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset_n = 1'b1;

      // Poll period with nothing pending
      n = 0;
      while (address_o !== RD && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("poll_found", address_o, RD);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (address_o !== RD && n < 20);
      check("poll_period", n, PD + 1);

      // Single vector
      load(8'h04);
      grant(3'd2);
      finish(8'h00);
      check("single_ctrl", ctrl_reg, 8'h00);

      // Fixed priority, with a held acknowledge in ACTIVE
      load(8'h90);
      grant(3'd4);
      ack_i = 1'b1;
      repeat (3) @(negedge clk);
      ack_i = 1'b0;
      check("ack_held_valid", vector_valid_o, 1);
      check("ack_held_id", vector_id_o, 3'd4);
      finish(8'h80);
      grant(3'd7);
      finish(8'h00);

      // New arrival during service
      load(8'h01);
      grant(3'd0);
      arrive = 8'h40;
      @(negedge clk);
      arrive = 8'h00;
      finish(8'h40);
      grant(3'd6);
      finish(8'h00);

      // Mask: bit 0 stays pending and is never requested
      mask_i = 8'h01;
      load(8'h03);
      grant(3'd1);
      finish(8'h01);
      quiet_bad = 0;
      w0 = wr_cnt;
      eoi_i = 1'b1;
      @(negedge clk);
      eoi_i = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (irq_o !== 1'b0 || we_o !== 1'b0) quiet_bad++;
      end
      check("mask_quiet", quiet_bad, 0);
      check("mask_no_write", wr_cnt - w0, 0);
      check("mask_ctrl", ctrl_reg, 8'h01);

      // Reset held 3 cycles while ACTIVE
      load(8'h04);
      grant(3'd2);
      w0 = wr_cnt;
      quiet_bad = 0;
      reset_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (we_o !== 1'b0) quiet_bad++;
      end
      check("reset_we_pulse", quiet_bad, 0);
      check_reset_outputs("mid_reset");
      reset_n = 1'b1;
      check("reset_ctrl", ctrl_reg, 8'h04);
      check("reset_no_write", wr_cnt - w0, 0);

      // Always-pending 0x05 right after reset
      mask_i = 8'h00;
      arrive = 8'h05;
`ifdef INT_DISPATCH_ROUNDROBIN_EN
      grant(3'd0);
      finish(8'h04);
      grant(3'd2);
      finish(8'h01);
      grant(3'd0);
      finish(8'h04);
      grant(3'd2);
      finish(8'h01);
`else
      grant(3'd0);
      finish(8'h04);
      grant(3'd0);
      finish(8'h04);
      grant(3'd0);
      finish(8'h04);
`endif
      arrive = 8'h00;
      check("bad_write_addr", bad_wr, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
